rand_range_sampler: RTL and testbench

RAND_RANGE_SAMPLER -- requirements
Module: rand_range_sampler

---
 rtl/rand_range_sampler.sv | 169 ++++++++++++++++
 tb/tb_rand_range_sampler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rand_range_sampler.sv
// rand_range_sampler
//
// Draws a uniformly distributed index in [0, bound-1] from an external random
// generator. It uses rejection sampling: each candidate is masked to the
// smallest power-of-two range covering the bound. After MAX_TRIES rejected
// candidates, the last candidate is folded back into range by subtracting the
// bound.
//
// Parameters
//   WIDTH      random word / bound / result width
//   MAX_TRIES  rejection attempts per request before fallback (1..255)
//
// Ports
//   clk             clock, all state changes on posedge
//   rst_n           asynchronous active-low reset
//   lfsr_data       current registered output of the random generator
//   lfsr_enable     advance strobe to the generator (one value per high cycle)
//   req_valid       request present
//   req_ready       request accepted (high only when idle)
//   bound           N; requested range is [0, N-1]
//   result_valid    result present
//   result_ready    result consumed
//   result          sampled index
//   result_fallback result came from the fold-back path
//   result_error    request had bound == 0
module rand_range_sampler #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lfsr_data,
    output logic             lfsr_enable,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] bound,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_fallback,
    output logic             result_error
);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

    state_t           state, state_next;
    logic [WIDTH-1:0] bound_q, bound_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             fallback_q, fallback_d;
    logic             error_q, error_d;
    logic [7:0]       tries_q, tries_d;

    logic [WIDTH-1:0] bound_m1;
    logic [WIDTH-1:0] mask_new;
    logic             smear;
    logic [WIDTH-1:0] candidate;
    logic             accept;
    logic [WIDTH-1:0] folded;

    // The mask is (bound-1) with every bit below its MSB set. That is
    // 2^k-1 for the smallest k with 2^k >= bound, and bound=1 gives mask 0.
    always_comb begin
        bound_m1 = bound - WIDTH'(1);
        smear    = 1'b0;
        mask_new = '0;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            smear                  = smear | bound_m1[WIDTH-1-j];
            mask_new[WIDTH-1-j]    = smear;
        end
    end

    assign candidate = lfsr_data & mask_q;
    assign accept    = (candidate < bound_q);
    // A masked candidate is below 2*bound, so one subtraction lands in range.
    assign folded    = candidate - bound_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bound_q    <= '0;
            mask_q     <= '0;
            result_q   <= '0;
            fallback_q <= 1'b0;
            error_q    <= 1'b0;
            tries_q    <= '0;
        end else begin
            state      <= state_next;
            bound_q    <= bound_d;
            mask_q     <= mask_d;
            result_q   <= result_d;
            fallback_q <= fallback_d;
            error_q    <= error_d;
            tries_q    <= tries_d;
        end
    end

    always_comb begin
        state_next   = state;
        bound_d      = bound_q;
        mask_d       = mask_q;
        result_d     = result_q;
        fallback_d   = fallback_q;
        error_d      = error_q;
        tries_d      = tries_q;
        req_ready    = 1'b0;
        lfsr_enable  = 1'b0;
        result_valid = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    bound_d    = bound;
                    mask_d     = mask_new;
                    tries_d    = '0;
                    result_d   = '0;
                    fallback_d = 1'b0;
                    error_d    = 1'b0;
                    if (bound == '0) begin
                        // Empty range: report it without consuming randomness.
                        error_d    = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = SAMPLE;
                    end
                end
            end

            SAMPLE: begin
                lfsr_enable = 1'b1;
                if (accept) begin
                    result_d   = candidate;
                    fallback_d = 1'b0;
                    state_next = DONE;
                end else begin
                    tries_d = tries_q + 8'd1;
                    if (tries_q == LAST_TRY) begin
                        result_d   = folded;
                        fallback_d = 1'b1;
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign result          = result_q;
    assign result_fallback = fallback_q;
    assign result_error    = error_q;

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed testbench for rand_range_sampler (WIDTH=8, MAX_TRIES=4).
// Inputs are driven and outputs are checked on the falling clock edge.
module tb_rand_range_sampler;

    logic       clk;
    logic       rst_n;
    logic [7:0] lfsr_data;
    logic       lfsr_enable;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] bound;
    logic       result_valid;
    logic       result_ready;
    logic [7:0] result;
    logic       result_fallback;
    logic       result_error;

    int tests = 0;
    int fails = 0;
    int en_count = 0;

    rand_range_sampler #(
        .WIDTH    (8),
        .MAX_TRIES(4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lfsr_data      (lfsr_data),
        .lfsr_enable    (lfsr_enable),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .bound          (bound),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .result         (result),
        .result_fallback(result_fallback),
        .result_error   (result_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One SAMPLE cycle spans exactly one falling edge.
    always @(negedge clk) begin
        if (lfsr_enable) en_count++;
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Issue one request and check the outcome. d0..d3 are fed to lfsr_data on
    // successive SAMPLE cycles (the last value repeats). Latency counts falling
    // edges after the handshake edge until result_valid is seen.
    task automatic run_req(input logic [7:0] b,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input int hold,
                           input logic [7:0] exp_res, input logic exp_fb,
                           input logic exp_err, input int exp_lat,
                           input int exp_pulses);
        int base;
        int lat;
        int idx;
        logic [7:0] seq [4];
        seq[0] = d0; seq[1] = d1; seq[2] = d2; seq[3] = d3;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        bound     = b;
        req_valid = 1'b1;
        lfsr_data = d0;
        base      = en_count;
        idx       = 0;
        @(negedge clk);
        req_valid = 1'b0;
        lat       = 1;
        while (!result_valid && lat < 20) begin
            if (lfsr_enable) begin
                lfsr_data = seq[idx];
                if (idx < 3) idx++;
            end
            @(negedge clk);
            lat++;
        end
        chk("result_valid", 32'(result_valid), 32'd1);
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("result", 32'(result), 32'(exp_res));
        chk("fallback", 32'(result_fallback), 32'(exp_fb));
        chk("error", 32'(result_error), 32'(exp_err));
        chk("enable_pulses", 32'(en_count - base), 32'(exp_pulses));
        chk("req_ready_done", 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            lfsr_data = 8'($urandom);
            bound     = 8'($urandom);
            @(negedge clk);
            chk("hold_result", 32'(result), 32'(exp_res));
            chk("hold_valid", 32'(result_valid), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            chk("hold_enable", 32'(lfsr_enable), 32'd0);
            chk("hold_fallback", 32'(result_fallback), 32'(exp_fb));
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("idle_after_done", 32'(req_ready), 32'd1);
        chk("valid_after_done", 32'(result_valid), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        bound        = '0;
        lfsr_data    = '0;
        result_ready = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_enable", 32'(lfsr_enable), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_fallback", 32'(result_fallback), 32'd0);
        chk("rst_error", 32'(result_error), 32'd0);
        rst_n = 1'b1;

        // 0x35 & 0xF = 5 < 10: first-try accept; held 5 cycles in DONE.
        run_req(8'd10, 8'h35, 8'h35, 8'h35, 8'h35, 5, 8'd5, 1'b0, 1'b0, 2, 1);
        // 12, 15 rejected, 7 accepted.
        run_req(8'd10, 8'h0C, 8'h0F, 8'h07, 8'h07, 0, 8'd7, 1'b0, 1'b0, 4, 3);
        // 14 rejected 4 times -> 14-10 = 4 via fallback.
        run_req(8'd10, 8'h0E, 8'h0E, 8'h0E, 8'h0E, 2, 8'd4, 1'b1, 1'b0, 5, 4);
        // Empty range.
        run_req(8'd0, 8'hAB, 8'hAB, 8'hAB, 8'hAB, 1, 8'd0, 1'b0, 1'b1, 1, 0);
        // Power of two: 0xAB & 0xF = 11.
        run_req(8'd16, 8'hAB, 8'hAB, 8'hAB, 8'hAB, 0, 8'd11, 1'b0, 1'b0, 2, 1);
        // N=1: mask 0, always 0.
        run_req(8'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 8'd0, 1'b0, 1'b0, 2, 1);
        // N=255: mask 0xFF, 254 accepted.
        run_req(8'd255, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 0, 8'hFE, 1'b0, 1'b0, 2, 1);
        // N=129: mask 0xFF, 200 rejected 4 times -> 71.
        run_req(8'd129, 8'hC8, 8'hC8, 8'hC8, 8'hC8, 0, 8'd71, 1'b1, 1'b0, 5, 4);
        // N=3: mask 3; 3, 3 rejected, 2 accepted.
        run_req(8'd3, 8'h07, 8'h03, 8'h02, 8'h02, 0, 8'd2, 1'b0, 1'b0, 4, 3);

        // Reset during SAMPLE with rejecting data.
        @(negedge clk);
        bound     = 8'd10;
        req_valid = 1'b1;
        lfsr_data = 8'h0E;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_enable_1", 32'(lfsr_enable), 32'd1);
        @(negedge clk);
        chk("mid_enable_2", 32'(lfsr_enable), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_enable", 32'(lfsr_enable), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
        chk("mid_rst_valid", 32'(result_valid), 32'd0);
        chk("mid_rst_result", 32'(result), 32'd0);
        chk("mid_rst_fallback", 32'(result_fallback), 32'd0);
        chk("mid_rst_error", 32'(result_error), 32'd0);
        @(negedge clk);
        chk("rst_hold_enable", 32'(lfsr_enable), 32'd0);

        // Request accepted on the first edge after release.
        rst_n     = 1'b1;
        bound     = 8'd1;
        req_valid = 1'b1;
        lfsr_data = 8'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        chk("post_rst_accept", 32'(req_ready), 32'd0);
        chk("post_rst_enable", 32'(lfsr_enable), 32'd1);
        @(negedge clk);
        chk("post_rst_valid", 32'(result_valid), 32'd1);
        chk("post_rst_result", 32'(result), 32'd0);
        chk("post_rst_error", 32'(result_error), 32'd0);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        chk("post_rst_idle", 32'(req_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
